// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter guarding a single shared WIDTH-bit register.
// Each requester holds req until it sees its one-cycle ack. Every write takes
// an IDLE arbitration cycle plus a WRITE cycle. An optional GAP dead time can
// follow each completed write.
module shared_reg_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 0,
  localparam int unsigned OW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   data,
  output logic [WIDTH-1:0]           q,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic [OW-1:0]              owner,
  output logic                       busy
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [OW-1:0]        win_q, win_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [OW-1:0]        cand;
  logic [OW-1:0]        pick_idx;
  logic                 found;

  // Unflatten the per-requester data lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = data[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first eligible requester at or after ptr, wrapping.
  // A requester whose ack is high this cycle is masked so a held req re-arbitrates later.
  always_comb begin
    eligible = req & ~ack_q;
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = OW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    grant_d = '0;
    ack_d   = '0;
    owner_d = owner_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
          win_d   = pick_idx;
          ptr_d   = (pick_idx == OW'(NUM_REQ - 1)) ? '0 : pick_idx + OW'(1);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (req[win_q]) begin
          q_d     = data_arr[win_q];
          owner_d = win_q;
          ack_d   = NUM_REQ'(1) << win_q;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = CW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end else begin
          // Requester withdrew: drop the write, pointer stays advanced.
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q     = q_q;
  assign grant = grant_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: one instance with no gap, one with a 3-cycle gap.
// Expected acks are queued as stimulus is applied; monitors pop them on each ack.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req0, req1, hold0;
  logic [31:0] data0, data1;
  logic [7:0]  q0, q1;
  logic [3:0]  grant0, grant1, ack0, ack1;
  logic [1:0]  owner0, owner1;
  logic        busy0, busy1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last0    = 0;
  int last1    = 0;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] q;
    logic [1:0] owner;
    int         gap;   // cycles since previous ack on this instance, 0 = unchecked
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  exp_t e0, e1;

  shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .req(req0), .data(data0),
    .q(q0), .grant(grant0), .ack(ack0), .owner(owner0), .busy(busy0)
  );

  shared_reg_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst_n), .req(req1), .data(data1),
    .q(q1), .grant(grant1), .ack(ack1), .owner(owner1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  // Advance to the next falling edge; requesters drop req on their ack unless held.
  task automatic step();
    @(negedge clk);
    req0 = req0 & ~(ack0 & ~hold0);
    req1 = req1 & ~ack1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_dut0", exp0.size(), 0);
    chk("drain_dut1", exp1.size(), 0);
  endtask

  // Scoreboard monitor for the gap-free instance.
  always @(negedge clk) begin
    if (rst_n && ack0 != 4'b0) begin
      if (exp0.size() == 0) begin
        chk("dut0_unexpected_ack", ack0, 0);
      end else begin
        e0 = exp0.pop_front();
        chk("dut0_ack", ack0, e0.ack);
        chk("dut0_q", q0, e0.q);
        chk("dut0_owner", owner0, e0.owner);
        if (e0.gap != 0) chk("dut0_ack_spacing", cyc - last0, e0.gap);
      end
      last0 = cyc;
    end
  end

  // Scoreboard monitor for the gapped instance.
  always @(negedge clk) begin
    if (rst_n && ack1 != 4'b0) begin
      if (exp1.size() == 0) begin
        chk("dut1_unexpected_ack", ack1, 0);
      end else begin
        e1 = exp1.pop_front();
        chk("dut1_ack", ack1, e1.ack);
        chk("dut1_q", q1, e1.q);
        chk("dut1_owner", owner1, e1.owner);
        if (e1.gap != 0) chk("dut1_ack_spacing", cyc - last1, e1.gap);
      end
      last1 = cyc;
    end
  end

  logic       exp_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] exp_grant [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};

  initial begin
    rst_n = 1'b1; req0 = '0; req1 = '0; hold0 = '0; data0 = '0; data1 = '0;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", q0, 0);
    chk("rst_grant", grant0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_owner", owner0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_busy_gap_inst", busy1, 0);
    rst_n = 1'b1;
    step();

    // All four requesting: acks in order 0,1,2,3, two cycles apart.
    data0 = {8'h44, 8'h33, 8'h22, 8'h11};
    req0  = 4'b1111;
    exp0.push_back('{4'b0001, 8'h11, 2'd0, 0});
    exp0.push_back('{4'b0010, 8'h22, 2'd1, 2});
    exp0.push_back('{4'b0100, 8'h33, 2'd2, 2});
    exp0.push_back('{4'b1000, 8'h44, 2'd3, 2});
    drain(40);
    step();

    // Single request: grant after edge 1, write and ack after edge 2.
    data0 = {8'h00, 8'h00, 8'h3C, 8'h00};
    req0  = 4'b0010;
    exp0.push_back('{4'b0010, 8'h3C, 2'd1, 0});
    step();
    chk("single_grant", grant0, 4'b0010);
    chk("single_busy", busy0, 1);
    chk("single_no_early_ack", ack0, 0);
    step();
    chk("single_ack", ack0, 4'b0010);
    chk("single_q", q0, 8'h3C);
    step();
    chk("single_ack_clears", ack0, 0);
    chk("single_idle", busy0, 0);

    // Requester 3 withdraws while granted: no write, pointer has moved to 0.
    req0 = 4'b1000;
    step();
    chk("abort_grant", grant0, 4'b1000);
    req0 = 4'b0000;
    step();
    chk("abort_no_ack", ack0, 0);
    chk("abort_grant_off", grant0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_q_kept", q0, 8'h3C);
    chk("abort_owner_kept", owner0, 1);
    data0 = {8'hC3, 8'h00, 8'h00, 8'h5A};
    req0  = 4'b1001;
    exp0.push_back('{4'b0001, 8'h5A, 2'd0, 0});
    exp0.push_back('{4'b1000, 8'hC3, 2'd3, 2});
    drain(40);
    step();

    // Requester 1 holds req through its ack: others go first, then it re-arbitrates
    // only after its ack has cleared.
    data0 = {8'h43, 8'h00, 8'h21, 8'h10};
    hold0 = 4'b0010;
    req0  = 4'b1011;
    exp0.push_back('{4'b0001, 8'h10, 2'd0, 0});
    exp0.push_back('{4'b0010, 8'h21, 2'd1, 2});
    exp0.push_back('{4'b1000, 8'h43, 2'd3, 2});
    exp0.push_back('{4'b0010, 8'h21, 2'd1, 2});
    exp0.push_back('{4'b0010, 8'h21, 2'd1, 3});
    drain(40);
    req0  = 4'b0000;
    hold0 = 4'b0000;
    step();
    step();

    // Gapped instance: ack 0, busy through 3 gap cycles, then grant 2.
    data1 = {8'h00, 8'hF0, 8'h00, 8'h0F};
    req1  = 4'b0101;
    exp1.push_back('{4'b0001, 8'h0F, 2'd0, 0});
    exp1.push_back('{4'b0100, 8'hF0, 2'd2, 5});
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("gap_busy_%0d", i), busy1, exp_busy[i]);
      chk($sformatf("gap_grant_%0d", i), grant1, exp_grant[i]);
    end
    drain(40);
    step();

    // Reset asserted mid-write: outputs clear at once, nothing written afterwards.
    data0 = {8'h00, 8'hA5, 8'h00, 8'h00};
    req0  = 4'b0100;
    step();
    chk("rstmid_grant", grant0, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_q", q0, 0);
    chk("rstmid_ack", ack0, 0);
    chk("rstmid_grant_off", grant0, 0);
    chk("rstmid_busy", busy0, 0);
    chk("rstmid_owner", owner0, 0);
    req0 = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_rst_q", q0, 0);
    chk("post_rst_busy", busy0, 0);

    chk("final_queue_dut0", exp0.size(), 0);
    chk("final_queue_dut1", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
